// File: rtl/pipelined_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipelined_adder                                               |
// | Purpose  : WIDTH-bit add/subtract split into STAGES carry-chained chunks, |
// |            with valid/ready handshakes on both sides and a single global |
// |            advance enable. Optional signed-overflow output io_Ovf is     |
// |            built when PIPELINED_ADDER_OVF_EN is defined.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  input  logic             io_Cin,
  input  logic             io_Sub,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_Sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             io_Ovf,
`endif
  output logic             io_Cout
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction folds into the adder as A + ~B + ~Cin; io_Sub is not piped
  always_comb begin
    b_eff = io_Sub ? ~io_B : io_B;
    c0    = io_Cin ^ io_Sub;
  end

  // Whole pipe moves together unless a finished result waits on the consumer
  always_comb begin
    adv         = ~io_out_valid | io_out_ready;
    io_in_ready = adv;
  end

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * CHUNK;      // first operand bit handled here
    localparam int PEND = WIDTH - LO;     // operand bits not yet summed

    logic [PEND-1:0]     a_in;
    logic [PEND-1:0]     b_in;
    logic                c_in;
    logic                v_in;
    logic [CHUNK:0]      add;
    logic [LO+CHUNK-1:0] sum_d;
    logic [LO+CHUNK-1:0] sum_q;
    logic                carry_d;
    logic                carry_q;
    logic                valid_d;
    logic                valid_q;

    if (k == 0) begin : g_in
      // First stage takes the beat straight off the input port
      always_comb begin
        a_in = io_A;
        b_in = b_eff;
        c_in = c0;
        v_in = io_in_valid;
      end
      // Only one chunk of sum exists so far
      always_comb begin
        sum_d = add[CHUNK-1:0];
      end
    end else begin : g_in
      // Later stages consume the skewed operands and carry of the stage before
      always_comb begin
        a_in = g_stage[k-1].g_skew.a_q;
        b_in = g_stage[k-1].g_skew.b_q;
        c_in = g_stage[k-1].carry_q;
        v_in = g_stage[k-1].valid_q;
      end
      // New chunk is stacked on top of the lower sum chunks already computed
      always_comb begin
        sum_d = {add[CHUNK-1:0], g_stage[k-1].sum_q};
      end
    end

    // Chunk adder: this stage's slice of A and B_eff plus the incoming carry
    always_comb begin
      add     = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, c_in};
      carry_d = add[CHUNK];
      valid_d = v_in;
    end

    // Stage register; reset wins over adv, and adv=0 freezes the slot
    always_ff @(posedge clk) begin
      if (!reset) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else if (adv) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [PEND-CHUNK-1:0] a_d;
      logic [PEND-CHUNK-1:0] a_q;
      logic [PEND-CHUNK-1:0] b_d;
      logic [PEND-CHUNK-1:0] b_q;

      // Upper operand chunks ride along untouched for the later stages
      always_comb begin
        a_d = a_in[PEND-1:CHUNK];
        b_d = b_in[PEND-1:CHUNK];
      end

      // Skew registers follow the same reset/hold rule as the stage
      always_ff @(posedge clk) begin
        if (!reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  // Results come straight from the final stage registers
  always_comb begin
    io_out_valid = g_stage[STAGES-1].valid_q;
    io_Sum       = g_stage[STAGES-1].sum_q;
    io_Cout      = g_stage[STAGES-1].carry_q;
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the MSB disagrees with the carry out of it
  always_comb begin
    ovf_d = g_stage[STAGES-1].a_in[CHUNK-1] ^ g_stage[STAGES-1].b_in[CHUNK-1]
          ^ g_stage[STAGES-1].add[CHUNK-1]  ^ g_stage[STAGES-1].add[CHUNK];
  end

  // Overflow flag is registered alongside the final stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  // Expose the registered flag
  always_comb begin
    io_Ovf = ovf_q;
  end
`endif

endmodule
`default_nettype wire
